// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: operation and size encodings,
// FSM state, and the byte-lane / extension helpers used by lsu_unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    NOP     = 2'b00,
    ST      = 2'b01,
    LD      = 2'b10,
    NOP_ALT = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    HALF = 2'b01,
    BYTE = 2'b10
  } size_e;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    LD_RESP = 1'b1
  } lsu_state_e;

  // Encoding 2'b11 is treated as a word access.
  function automatic size_e decode_size(input logic [1:0] data_type);
    size_e size;
    case (data_type)
      2'b01:   size = HALF;
      2'b10:   size = BYTE;
      default: size = WORD;
    endcase
    return size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] off, input size_e size);
    logic mis;
    case (size)
      HALF:    mis = off[0];
      BYTE:    mis = 1'b0;
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

  // Offset bits below natural alignment are ignored, which truncates the access.
  function automatic logic [3:0] make_be(input logic [1:0] off, input size_e size);
    logic [3:0] be;
    case (size)
      BYTE:    be = 4'b0001 << off;
      HALF:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] make_wdata(input logic [31:0] data, input size_e size);
    logic [31:0] wdata;
    case (size)
      BYTE:    wdata = {4{data[7:0]}};
      HALF:    wdata = {2{data[15:0]}};
      default: wdata = data;
    endcase
    return wdata;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] off,
                                               input size_e size, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      BYTE:    res = is_unsigned ? {24'h000000, b} : {{24{b[7]}}, b};
      HALF:    res = is_unsigned ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_unit_dmem.sv
// Single-port data RAM, DEPTH_WORDS x 32, per-byte write enables and a registered
// (synchronous) read port. Contents are never reset.
module dmem #(
  parameter int DEPTH_WORDS = 512,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [3:0]       i_be,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rdata_r;

  // Byte-lane writes and synchronous read; read data holds between reads.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          mem_r[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      rdata_r <= mem_r[i_idx];
    end
  end

  assign o_rdata = rdata_r;

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: stores write in one cycle, loads stall one cycle for the RAM read.
// Optional feature macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses.
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int DMEM_DEPTH_WORDS = 512
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [1:0]  i_mem_wren,
  input  logic [1:0]  i_data_type,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_ld_data,
  output logic        o_ld_vld,
  output logic        o_stall,
  output logic        o_misalign
);

  localparam int IDX_W = $clog2(DMEM_DEPTH_WORDS);

  lsu_state_e       state_r, state_next_s;
  mem_op_e          op_s;
  size_e            size_s, size_r;
  logic [1:0]       off_r;
  logic             uns_r;
  logic [IDX_W-1:0] idx_s;
  logic             misalign_s;
  logic             ram_we_s, ram_re_s;
  logic             stall_s, ld_vld_s, misalign_flag_s;
  logic [31:0]      rdata_s;
  logic             unused_addr_s;

  assign op_s          = mem_op_e'(i_mem_wren);
  assign size_s        = decode_size(i_data_type);
  assign idx_s         = i_addr[IDX_W+1:2];
  assign unused_addr_s = ^i_addr[31:IDX_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = is_misaligned(i_addr[1:0], size_s);
`else
  assign misalign_s = 1'b0;
`endif

  // Next-state and per-cycle control; reset forces all outputs to idle values.
  always_comb begin
    state_next_s    = state_r;
    ram_we_s        = 1'b0;
    ram_re_s        = 1'b0;
    stall_s         = 1'b0;
    ld_vld_s        = 1'b0;
    misalign_flag_s = 1'b0;
    if (i_reset) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (((op_s == LD) || (op_s == ST)) && misalign_s) begin
            misalign_flag_s = 1'b1;
          end else if (op_s == LD) begin
            ram_re_s     = 1'b1;
            stall_s      = 1'b1;
            state_next_s = LD_RESP;
          end else if (op_s == ST) begin
            ram_we_s = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end
        // The load is still on the inputs here; it is not re-accepted.
        LD_RESP: begin
          ld_vld_s     = 1'b1;
          state_next_s = IDLE;
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture load attributes alongside the RAM read so extraction uses the issuing access.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      off_r  <= 2'b00;
      size_r <= WORD;
      uns_r  <= 1'b0;
    end else if (ram_re_s) begin
      off_r  <= i_addr[1:0];
      size_r <= size_s;
      uns_r  <= i_unsigned;
    end
  end

  dmem #(
    .DEPTH_WORDS(DMEM_DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_dmem (
    .i_clk  (i_clk),
    .i_we   (ram_we_s),
    .i_re   (ram_re_s),
    .i_be   (make_be(i_addr[1:0], size_s)),
    .i_idx  (idx_s),
    .i_wdata(make_wdata(i_st_data, size_s)),
    .o_rdata(rdata_s)
  );

  assign o_ld_data  = ld_vld_s ? extract_load(rdata_s, off_r, size_r, uns_r) : 32'h0000_0000;
  assign o_ld_vld   = ld_vld_s;
  assign o_stall    = stall_s;
  assign o_misalign = misalign_flag_s;

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: stimulus pushes expected load results, a monitor
// pops them when o_ld_vld rises; a byte-array model gives the expected values.
module tb_lsu_unit;

  localparam int MEM_BYTES = 2048;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [1:0]  i_mem_wren;
  logic [1:0]  i_data_type;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_st_data;
  logic [31:0] o_ld_data;
  logic        o_ld_vld;
  logic        o_stall;
  logic        o_misalign;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  ref_mem [MEM_BYTES];

  lsu_unit #(.DMEM_DEPTH_WORDS(512)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_mem_wren (i_mem_wren),
    .i_data_type(i_data_type),
    .i_unsigned (i_unsigned),
    .i_addr     (i_addr),
    .i_st_data  (i_st_data),
    .o_ld_data  (o_ld_data),
    .o_ld_vld   (o_ld_vld),
    .o_stall    (o_stall),
    .o_misalign (o_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit trap(input logic [31:0] a, input logic [1:0] dt);
`ifdef LSU_MISALIGN_TRAP_EN
    if (dt == 2'b10) return 1'b0;
    if (dt == 2'b01) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] dt);
    if (dt == 2'b10) return 1;
    if (dt == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int base_of(input logic [31:0] a, input logic [1:0] dt);
    int n;
    n = nbytes(dt);
    return ((a % MEM_BYTES) / n) * n;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] dt, input logic u);
    int          n, base;
    logic [31:0] v;
    n    = nbytes(dt);
    base = base_of(a, dt);
    v    = 32'h0;
    for (int k = n - 1; k >= 0; k--) v = (v << 8) | 32'(ref_mem[base + k]);
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] dt, input logic [31:0] d);
    int n, base;
    n    = nbytes(dt);
    base = base_of(a, dt);
    for (int k = 0; k < n; k++) ref_mem[base + k] = d[8*k +: 8];
  endtask

  // Load results are compared in arrival order; an idle port must read zero.
  always @(negedge clk) begin
    if (o_ld_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ld_vld", {31'h0, o_ld_vld}, 32'h0);
      end else begin
        check("ld_data", o_ld_data, exp_q.pop_front());
      end
    end else begin
      check("ld_data_idle", o_ld_data, 32'h0);
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [1:0] dt,
                       input logic u, input logic [31:0] d);
    @(posedge clk); #1;
    i_reset = 1'b0; i_mem_wren = op; i_addr = a; i_data_type = dt; i_unsigned = u; i_st_data = d;
  endtask

  task automatic do_nop(input logic [1:0] op);
    drive(op, 32'($urandom), 2'($urandom), 1'($urandom), 32'($urandom));
    @(negedge clk);
    check("nop_stall", {31'h0, o_stall}, 32'h0);
    check("nop_misalign", {31'h0, o_misalign}, 32'h0);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [1:0] dt, input logic [31:0] d);
    drive(2'b01, a, dt, 1'b0, d);
    @(negedge clk);
    check("st_stall", {31'h0, o_stall}, 32'h0);
    check("st_misalign", {31'h0, o_misalign}, {31'h0, trap(a, dt)});
    if (!trap(a, dt)) ref_store(a, dt, d);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] dt, input logic u,
                         input logic [31:0] exp);
    drive(2'b10, a, dt, u, 32'($urandom));
    @(negedge clk);
    check("ld_misalign", {31'h0, o_misalign}, {31'h0, trap(a, dt)});
    if (trap(a, dt)) begin
      check("ld_trap_stall", {31'h0, o_stall}, 32'h0);
    end else begin
      check("ld_stall_n", {31'h0, o_stall}, 32'h1);
      exp_q.push_back(exp);
      @(posedge clk); #1;
      @(negedge clk);
      check("ld_stall_n1", {31'h0, o_stall}, 32'h0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  dt, op;
    logic        u;
    int          wait_cycles;

    i_reset = 1'b1; i_mem_wren = 2'b10; i_data_type = 2'b00; i_unsigned = 1'b0;
    i_addr = 32'h10; i_st_data = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'h0, o_stall}, 32'h0);
    check("rst_ld_vld", {31'h0, o_ld_vld}, 32'h0);
    check("rst_misalign", {31'h0, o_misalign}, 32'h0);
    check("rst_ld_data", o_ld_data, 32'h0);

    for (int w = 0; w < 16; w++) do_store(32'(w * 4), 2'b00, 32'($urandom));

    do_store(32'h10, 2'b00, 32'hDEADBEEF);
    do_load(32'h10, 2'b00, 1'b0, 32'hDEADBEEF);
    do_load(32'h13, 2'b10, 1'b0, 32'hFFFFFFDE);
    do_load(32'h13, 2'b10, 1'b1, 32'h000000DE);
    do_load(32'h10, 2'b01, 1'b0, 32'hFFFFBEEF);
    do_load(32'h12, 2'b01, 1'b1, 32'h0000DEAD);
    do_store(32'h11, 2'b10, 32'h12345655);
    do_load(32'h10, 2'b00, 1'b0, 32'hDEAD55EF);
    do_store(32'h810, 2'b00, 32'hCAFEF00D);
    do_load(32'h010, 2'b00, 1'b0, 32'hCAFEF00D);
    do_store(32'h12, 2'b00, 32'hAAAA5555);
    do_load(32'h12, 2'b00, 1'b0, ref_load(32'h12, 2'b00, 1'b0));
    do_load(32'h10, 2'b00, 1'b0, ref_load(32'h10, 2'b00, 1'b0));
    do_nop(2'b00);
    do_nop(2'b11);

    // Reset while the load response is pending aborts it.
    drive(2'b10, 32'h10, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    check("abort_stall_n", {31'h0, o_stall}, 32'h1);
    @(posedge clk); #1;
    i_reset = 1'b1; i_mem_wren = 2'b00;
    @(negedge clk);
    check("abort_vld_in_rst", {31'h0, o_ld_vld}, 32'h0);
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(negedge clk);
    check("abort_vld_after", {31'h0, o_ld_vld}, 32'h0);
    check("abort_stall_after", {31'h0, o_stall}, 32'h0);
    do_load(32'h10, 2'b00, 1'b0, ref_load(32'h10, 2'b00, 1'b0));

    for (int i = 0; i < 400; i++) begin
      a  = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 11) |
           (32'($urandom_range(0, 1)) << 20);
      dt = 2'($urandom_range(0, 3));
      u  = 1'($urandom_range(0, 1));
      d  = 32'($urandom);
      op = 2'($urandom_range(0, 3));
      case (op)
        2'b01:   do_store(a, dt, d);
        2'b10:   do_load(a, dt, u, ref_load(a, dt, u));
        default: do_nop(op);
      endcase
    end

    drive(2'b00, 32'h0, 2'b00, 1'b0, 32'h0);
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
LSU_UNIT -- requirements
Module: lsu_unit

Interface
REQ-001 SHALL have parameter DMEM_DEPTH_WORDS, default 512, data RAM depth in 32-bit words (2 KiB).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 SHALL have port i_clk, input, 1, rising-edge clock.
REQ-004 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_mem_wren, input, 2, operation: 2'b10 load, 2'b01 store, 2'b00/2'b11 no-op.
REQ-006 SHALL have port i_data_type, input, 2, access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-007 SHALL have port i_unsigned, input, 1, load zero-extend when 1, sign-extend when 0.
REQ-008 SHALL have port i_addr, input, 32, byte address from the ALU.
REQ-009 SHALL have port i_st_data, input, 32, store data; only the low byte/half is used for byte/half stores.
REQ-010 SHALL have port o_ld_data, output, 32, extended load result, valid only while o_ld_vld=1, else 32'h0.
REQ-011 SHALL have port o_ld_vld, output, 1, load result valid this cycle.
REQ-012 SHALL have port o_stall, output, 1, core holds the instruction and all inputs stable while 1.
REQ-013 SHALL have port o_misalign, output, 1, misaligned access flag.

Function
REQ-014 SHALL implement FSM states IDLE and LD_RESP.
REQ-015 In IDLE with a load (cycle N), the block SHALL issue a synchronous RAM read, register addr[1:0], size and unsigned, drive o_stall=1 combinationally, and go to LD_RESP.
REQ-016 In LD_RESP (N+1), the block SHALL drive o_ld_vld=1 and o_stall=0, drive o_ld_data from the RAM word, and return to IDLE unconditionally; the still-present load SHALL NOT be re-accepted. Load latency is 1 stall cycle.
REQ-017 Load extraction: byte lane = addr[1:0]; half lane = addr[1]; extension per i_unsigned; word passes unchanged.
REQ-018 A store in IDLE SHALL write at the same clock edge using byte enables (byte: 1 lane; half: 2 lanes; word: 4), with no stall.
REQ-019 Word index SHALL be i_addr[$clog2(DMEM_DEPTH_WORDS)+1:2]; upper bits are ignored, so addresses wrap modulo RAM size.
REQ-020 No-op encodings SHALL leave the RAM untouched and the outputs at idle values.
REQ-021 A store to an address followed immediately by a load from it SHALL return the new data (RAM write-before-read across edges).

Reset
REQ-022 On i_reset, the state SHALL go to IDLE and o_stall, o_ld_vld, o_misalign and o_ld_data SHALL all be 0.
REQ-023 RAM contents SHALL NOT be reset.
REQ-024 Reset asserted in LD_RESP SHALL abort the load; o_ld_vld SHALL be 0 in the cycle after reset.

Configuration
REQ-025 Macro LSU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL drive o_misalign=1 combinationally in IDLE, perform no RAM write or read, drive o_stall=0, and leave o_ld_vld=0.
REQ-026 Macro LSU_MISALIGN_TRAP_EN undefined: the low address bits SHALL be truncated to natural alignment and o_misalign SHALL be tied 0.

Structure
REQ-027 Package lsu_pkg SHALL hold the mem_op enum (LD=2'b10, ST=2'b01), the size enum (WORD, HALF, BYTE), and the FSM state typedef.
REQ-028 Sub-module dmem SHALL be a byte-enabled, synchronous-read, single-port RAM of DMEM_DEPTH_WORDS x 32.

Verification
REQ-029 Store word 32'hDEADBEEF @0x10, then load word @0x10 -> o_stall=1 for 1 cycle, then o_ld_vld=1 with o_ld_data=32'hDEADBEEF.
REQ-030 Load byte signed @0x13 after the word above -> 32'hFFFFFFDE; load byte unsigned @0x13 -> 32'h000000DE; load half signed @0x10 -> 32'hFFFFBEEF.
REQ-031 Store byte 8'h55 @0x11 over 32'hDEADBEEF -> load word @0x10 returns 32'hDEAD55EF.
REQ-032 Store word @0x810 with DMEM_DEPTH_WORDS=512 -> load @0x010 returns the same data (wrap-around).
REQ-033 With the macro defined, load word @0x12 -> o_misalign=1, o_stall=0, o_ld_vld=0, and the RAM is unchanged; without the macro, the access goes to @0x10.
REQ-034 Assert i_reset in LD_RESP -> the next cycle has o_ld_vld=0, o_stall=0, and the state is IDLE.
